loom_emu_clkseq: RTL and testbench
==================================

// Module: loom_emu_clkseq
// PURPOSE
// - Multi-domain emulation sequencer: run/stop/step/reset state machine.
// - Generates N_DOMAINS divided DUT clock enables from one base tick.
// - 64-bit-capable cycle counter, sticky IRQs; sits behind the Loom reg-bus adapter in the shell.
// PARAMETERS
// N_DOMAINS    2   number of DUT clock-enable outputs (1..8)
// N_DPI_FUNCS  1   width of dpi_stall_i (>=1)
// CNT_W        64  cycle counter width (33..64)
// DIV_W        16  per-domain divider register width (1..16)
// PORTS
// clk_i          in   1             emulation clock
// rst_i          in   1             async active-high reset
// reg_req_i      in   1             register access request, held until reg_ack_o
// reg_we_i       in   1             1 = write, 0 = read
// reg_addr_i     in   8             byte address, bits [1:0] ignored
// reg_wdata_i    in   32            write data
// reg_rdata_o    out  32            read data, valid while reg_ack_o
// reg_ack_o      out  1             one-cycle access completion
// dpi_stall_i    in   N_DPI_FUNCS   any bit high freezes all domains
// emu_clk_en_o   out  N_DOMAINS     per-domain DUT clock enable
// dut_rst_no     out  1             DUT reset, active low
// cycle_count_o  out  CNT_W         base-tick counter
// irq_o          out  1             |(IRQ_STATUS & IRQ_ENABLE)
// BEHAVIOUR
// - Reset: state IDLE, emu_clk_en_o=0, dut_rst_no=0, cycle=0, STEP_COUNT=1, DIV[*]=0.
// - Reset also clears div counters, IRQ regs, reg_ack_o and reg_rdata_o. rst_i mid-access drops the access.
// - Regs: 00 STATUS(R, state[2:0]); 04 CONTROL(W, cmd[7:0]); 08/0C CYCLE_LO/HI(R, zero-ext); 10 STEP_COUNT(RW).
// - Regs: 14 DUT_RESET(W: b0 assert, b1 release, both => assert); 18 IRQ_STATUS(R/W1C); 1C IRQ_ENABLE(RW).
// - Regs: 20/24 BREAK_LO/HI(RW); 40+4*d DIV[d](RW). Unmapped read -> 32'hDEAD_BEEF; unmapped write ignored.
// - Bus: reg_ack_o rises exactly 1 cycle after reg_req_i is sampled. Requester drops req the cycle after ack.
// - Bus: no back-to-back accesses. A write takes effect on the ack edge.
// - States: IDLE=0, RUNNING=1, FROZEN=2, STEPPING=3. Cmds: 01 START, 02 STOP, 03 STEP, 04 RESET.
// - Commands are acted on the cycle after the CONTROL write.
// - IDLE: START->RUNNING, STEP->STEPPING. RUNNING: STOP->FROZEN, RESET->IDLE.
// - FROZEN: START/STEP/RESET as above. STEPPING: STOP->FROZEN; remaining==0 after a tick ->FROZEN.
// - Unlisted cmd/state pairs are ignored.
// - Entering STEPPING loads remaining=STEP_COUNT. STEP_COUNT=0: zero ticks, FROZEN next cycle, step-done IRQ set.
// - tick = (RUNNING | (STEPPING & remaining>0)) & ~|dpi_stall_i; combinational from registered state.
// - Per domain: emu_clk_en_o[d] = tick & (div_cnt[d]==0), same cycle as tick.
// - On tick: div_cnt[d] wraps to 0 if it equals DIV[d], else increments. Enable period = DIV[d]+1 ticks.
// - Writing DIV[d] clears div_cnt[d].
// - On tick: cycle+1 (wraps modulo 2^CNT_W) and, when STEPPING, remaining-1. In IDLE the counter is held at 0.
// - IRQ_STATUS sticky bits: b0 state changed, b1 step done (STEPPING->FROZEN by count), b2 breakpoint hit.
// - IRQ same-cycle set and W1C: set wins.
// - Simultaneous STOP cmd and step expiry -> FROZEN, b1 set. RESET cmd has no effect on dut_rst_no.
// CONFIGURATION
// - LOOM_EMU_BREAKPOINT_EN defined: BREAK regs exist (zero-ext to 64, reset all-ones).
// - With it: a tick making cycle == BREAK forces FROZEN next cycle, so exactly BREAK ticks execute, and sets b2.
// - Breakpoint-to-FROZEN has priority over STOP in the same cycle (b2 still set).
// - Not defined: 20/24 read DEAD_BEEF, writes ignored, IRQ b2 reads 0.
// TESTING
// - DIV={0,2}, START, 9 cycles -> en[0] high 9 cycles, en[1] on cycles 1,4,7; CYCLE_LO=9.
// - STEP_COUNT=5, STEP from FROZEN -> exactly 5 ticks, STATUS=2, IRQ b1=1; irq_o=1 with ENABLE=2.
// - RUNNING, dpi_stall_i held 4 cycles -> all en=0 and cycle frozen for those 4 cycles, resume after.
// - STEP_COUNT=0 -> STATUS=2 after 2 cycles, cycle unchanged, b1 set.
// - Write IRQ_STATUS=7 -> reads 0.
// - CYCLE preset near 2^32 via run -> CYCLE_HI increments on LO wrap. DUT_RESET=3 -> dut_rst_no=0; =2 -> 1.
// - Breakpoint (LOOM_EMU_BREAKPOINT_EN): BREAK=100, START -> FROZEN with CYCLE=100, b2=1.
// - Breakpoint (LOOM_EMU_BREAKPOINT_EN): rst_i pulse while RUNNING -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/loom_emu_clkseq.sv
// Multi-domain emulation sequencer: run/stop/step FSM, divided clock enables, cycle counter, sticky IRQs.
// Optional breakpoint registers are compiled in when LOOM_EMU_BREAKPOINT_EN is defined.
module loom_emu_clkseq #(
    parameter int N_DOMAINS   = 2,
    parameter int N_DPI_FUNCS = 1,
    parameter int CNT_W       = 64,
    parameter int DIV_W       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   reg_req_i,
    input  logic                   reg_we_i,
    input  logic [7:0]             reg_addr_i,
    input  logic [31:0]            reg_wdata_i,
    output logic [31:0]            reg_rdata_o,
    output logic                   reg_ack_o,
    input  logic [N_DPI_FUNCS-1:0] dpi_stall_i,
    output logic [N_DOMAINS-1:0]   emu_clk_en_o,
    output logic                   dut_rst_no,
    output logic [CNT_W-1:0]       cycle_count_o,
    output logic                   irq_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUNNING  = 3'd1,
        FROZEN   = 3'd2,
        STEPPING = 3'd3
    } state_t;

    typedef enum logic [7:0] {
        CMD_START = 8'h01,
        CMD_STOP  = 8'h02,
        CMD_STEP  = 8'h03,
        CMD_RESET = 8'h04
    } cmd_t;

    typedef enum logic [5:0] {
        A_STATUS     = 6'h00,
        A_CONTROL    = 6'h01,
        A_CYCLE_LO   = 6'h02,
        A_CYCLE_HI   = 6'h03,
        A_STEP_COUNT = 6'h04,
        A_DUT_RESET  = 6'h05,
        A_IRQ_STATUS = 6'h06,
        A_IRQ_ENABLE = 6'h07,
        A_BREAK_LO   = 6'h08,
        A_BREAK_HI   = 6'h09
    } addr_t;

    state_t             state, state_next;
    logic               cmd_valid;
    logic [7:0]         cmd_code;
    logic [CNT_W-1:0]   cycle;
    logic [31:0]        step_count, remaining, rem_after;
    logic [DIV_W-1:0]   div_reg [N_DOMAINS];
    logic [DIV_W-1:0]   div_cnt [N_DOMAINS];
    logic [2:0]         irq_status, irq_enable, irq_set;
    logic               dut_rst_n;
    logic               tick;
    logic               access, wr;
    logic [5:0]         word;
    logic [31:0]        rd_val;
    logic [63:0]        cycle64;
    logic [N_DOMAINS-1:0] div_wr;
    logic               is_start, is_stop, is_step, is_reset;
    logic               unused_addr;
`ifdef LOOM_EMU_BREAKPOINT_EN
    logic [63:0]        brk;
    logic               bp_hit;
`endif

    assign access      = reg_req_i & ~reg_ack_o;
    assign wr          = access & reg_we_i;
    assign word        = reg_addr_i[7:2];
    assign unused_addr = ^reg_addr_i[1:0];
    assign cycle64     = 64'(cycle);

    assign is_start = cmd_valid && (cmd_code == CMD_START);
    assign is_stop  = cmd_valid && (cmd_code == CMD_STOP);
    assign is_step  = cmd_valid && (cmd_code == CMD_STEP);
    assign is_reset = cmd_valid && (cmd_code == CMD_RESET);

    assign tick = ((state == RUNNING) || ((state == STEPPING) && (remaining != '0)))
                  && !(|dpi_stall_i);
    assign rem_after = tick ? remaining - 32'd1 : remaining;

`ifdef LOOM_EMU_BREAKPOINT_EN
    assign bp_hit = tick && (64'(cycle + 1'b1) == brk);
`endif

    always_comb begin
        for (int unsigned d = 0; d < N_DOMAINS; d++) begin
            emu_clk_en_o[d] = tick && (div_cnt[d] == '0);
            div_wr[d]       = wr && (word == 6'(16 + d));
        end
    end

    always_comb begin
        rd_val = 32'hDEAD_BEEF;
        case (word)
            A_STATUS:     rd_val = 32'(state);
            A_CONTROL:    rd_val = '0;
            A_CYCLE_LO:   rd_val = cycle64[31:0];
            A_CYCLE_HI:   rd_val = cycle64[63:32];
            A_STEP_COUNT: rd_val = step_count;
            A_DUT_RESET:  rd_val = '0;
            A_IRQ_STATUS: rd_val = 32'(irq_status);
            A_IRQ_ENABLE: rd_val = 32'(irq_enable);
`ifdef LOOM_EMU_BREAKPOINT_EN
            A_BREAK_LO:   rd_val = brk[31:0];
            A_BREAK_HI:   rd_val = brk[63:32];
`endif
            default: begin
                for (int unsigned d = 0; d < N_DOMAINS; d++)
                    if (word == 6'(16 + d)) rd_val = 32'(div_reg[d]);
            end
        endcase
    end

    always_comb begin
        state_next = state;
        irq_set    = '0;
        case (state)
            IDLE: begin
                if (is_start)     state_next = RUNNING;
                else if (is_step) state_next = STEPPING;
            end
            RUNNING: begin
                if (is_stop)       state_next = FROZEN;
                else if (is_reset) state_next = IDLE;
            end
            FROZEN: begin
                if (is_start)      state_next = RUNNING;
                else if (is_step)  state_next = STEPPING;
                else if (is_reset) state_next = IDLE;
            end
            STEPPING: begin
                // expiry wins over a concurrent STOP so the step-done flag is not lost
                if (rem_after == '0) begin
                    state_next = FROZEN;
                    irq_set[1] = 1'b1;
                end else if (is_stop) begin
                    state_next = FROZEN;
                end
            end
            default: state_next = IDLE;
        endcase
`ifdef LOOM_EMU_BREAKPOINT_EN
        if (bp_hit) begin
            state_next = FROZEN;
            irq_set[2] = 1'b1;
        end
`endif
        if (state_next != state) irq_set[0] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            remaining <= '0;
            cycle     <= '0;
        end else begin
            state     <= state_next;
            cmd_valid <= wr && (word == A_CONTROL);
            if (wr && (word == A_CONTROL)) cmd_code <= reg_wdata_i[7:0];
            if ((state_next == STEPPING) && (state != STEPPING))
                remaining <= step_count;
            else if ((state == STEPPING) && tick)
                remaining <= remaining - 32'd1;
            if (state_next == IDLE) cycle <= '0;
            else if (tick)          cycle <= cycle + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned d = 0; d < N_DOMAINS; d++) begin
                div_reg[d] <= '0;
                div_cnt[d] <= '0;
            end
        end else begin
            for (int unsigned d = 0; d < N_DOMAINS; d++) begin
                if (div_wr[d]) begin
                    div_reg[d] <= reg_wdata_i[DIV_W-1:0];
                    div_cnt[d] <= '0;
                end else if (tick) begin
                    div_cnt[d] <= (div_cnt[d] == div_reg[d]) ? '0 : div_cnt[d] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            step_count  <= 32'd1;
            irq_status  <= '0;
            irq_enable  <= '0;
            dut_rst_n   <= 1'b0;
            reg_ack_o   <= 1'b0;
            reg_rdata_o <= '0;
`ifdef LOOM_EMU_BREAKPOINT_EN
            brk         <= '1;
`endif
        end else begin
            reg_ack_o <= access;
            if (access && !reg_we_i) reg_rdata_o <= rd_val;
            if (wr && (word == A_STEP_COUNT)) step_count <= reg_wdata_i;
            if (wr && (word == A_IRQ_ENABLE)) irq_enable <= reg_wdata_i[2:0];
            irq_status <= (irq_status & ~((wr && (word == A_IRQ_STATUS)) ? reg_wdata_i[2:0] : 3'b000))
                          | irq_set;
            if (wr && (word == A_DUT_RESET)) begin
                if (reg_wdata_i[0])      dut_rst_n <= 1'b0;
                else if (reg_wdata_i[1]) dut_rst_n <= 1'b1;
            end
`ifdef LOOM_EMU_BREAKPOINT_EN
            if (wr && (word == A_BREAK_LO)) brk[31:0]  <= reg_wdata_i;
            if (wr && (word == A_BREAK_HI)) brk[63:32] <= reg_wdata_i;
`endif
        end
    end

    assign dut_rst_no    = dut_rst_n;
    assign cycle_count_o = cycle;
    assign irq_o         = |(irq_status & irq_enable);

endmodule

// File: tb/tb_loom_emu_clkseq.sv
// Self-checking bench for loom_emu_clkseq: register reads go through a scoreboard queue.
// Breakpoint scenarios compile in only when LOOM_EMU_BREAKPOINT_EN is defined.
module tb_loom_emu_clkseq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack;
    logic [0:0]  stall = '0;
    logic [1:0]  en;
    logic        dut_rst_n;
    logic [63:0] cycle;
    logic        irq;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    string       name_q[$];

    loom_emu_clkseq #(.N_DOMAINS(2), .N_DPI_FUNCS(1), .CNT_W(64), .DIV_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr),
        .reg_wdata_i(wdata), .reg_rdata_o(rdata), .reg_ack_o(ack), .dpi_stall_i(stall),
        .emu_clk_en_o(en), .dut_rst_no(dut_rst_n), .cycle_count_o(cycle), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_access(input logic w, input logic [7:0] a, input logic [31:0] d,
                              output logic [31:0] r);
        logic got;
        got = 1'b0;
        r = 'x;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (ack) begin got = 1'b1; r = rdata; end
        end
        req = 1'b0; we = 1'b0;
        if (!got) begin
            checks++; failures++;
            $display("FAIL bus_timeout addr=%h: no ack within 8 cycles", a);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus_access(1'b1, a, d, r);
    endtask

    task automatic rd_exp(input string n, input logic [7:0] a, input logic [31:0] e);
        logic [31:0] r;
        exp_q.push_back(e);
        name_q.push_back(n);
        bus_access(1'b0, a, 32'h0, r);
        obs_q.push_back(r);
    endtask

    task automatic test_reset;
        logic [31:0] e, o; string n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({en, dut_rst_n, cycle, irq, ack, rdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: en=%b rst_n=%b cycle=%0d irq=%b ack=%b rdata=%h, required all zero",
                     en, dut_rst_n, cycle, irq, ack, rdata);
        end
        rst = 1'b0;
        rd_exp("status_reset", 8'h00, 32'd0);
        rd_exp("step_count_reset", 8'h10, 32'd1);
        rd_exp("irq_status_reset", 8'h18, 32'd0);
        rd_exp("div0_reset", 8'h40, 32'd0);
        rd_exp("cycle_hi_reset", 8'h0C, 32'd0);
`ifdef LOOM_EMU_BREAKPOINT_EN
        rd_exp("break_lo_reset", 8'h20, 32'hFFFF_FFFF);
`else
        wr(8'h20, 32'd5);
        rd_exp("break_lo_absent", 8'h20, 32'hDEAD_BEEF);
`endif
        rd_exp("unmapped_30", 8'h30, 32'hDEAD_BEEF);
        rd_exp("unmapped_div2", 8'h48, 32'hDEAD_BEEF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL %s: got %h required %h", n, o, e); end
        end
    endtask

    task automatic test_div_run;
        logic [31:0] e, o; string n;
        wr(8'h40, 32'd0);
        wr(8'h44, 32'd2);
        rd_exp("div1_readback", 8'h44, 32'd2);
        wr(8'h04, 32'h01);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            checks++;
            if (en[0] !== 1'b1 || en[1] !== ((i % 3) == 1) || cycle !== 64'(i - 1)) begin
                failures++;
                $display("FAIL div_run_cycle%0d: en=%b cycle=%0d required en0=1 en1=%0b cycle=%0d",
                         i, en, cycle, ((i % 3) == 1), i - 1);
            end
        end
        wr(8'h04, 32'h02);
        rd_exp("status_after_stop", 8'h00, 32'd2);
        rd_exp("cycle_lo_after_stop", 8'h08, 32'd11);
        rd_exp("cycle_hi_after_stop", 8'h0C, 32'd0);
        rd_exp("irq_state_change", 8'h18, 32'd1);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_masked: got %b required 0", irq); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL %s: got %h required %h", n, o, e); end
        end
    endtask

    task automatic test_step;
        logic [31:0] e, o; string n;
        int ticks;
        wr(8'h18, 32'd7);
        wr(8'h1C, 32'd2);
        wr(8'h10, 32'd5);
        wr(8'h04, 32'h03);
        ticks = 0;
        repeat (12) begin
            @(negedge clk);
            if (en[0] === 1'b1) ticks++;
        end
        checks++;
        if (ticks != 5 || cycle !== 64'd16) begin
            failures++;
            $display("FAIL step5_ticks: ticks=%0d cycle=%0d required 5 and 16", ticks, cycle);
        end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL step_irq: got %b required 1", irq); end
        rd_exp("status_after_step", 8'h00, 32'd2);
        rd_exp("irq_step_done", 8'h18, 32'd3);
        rd_exp("step_count_readback", 8'h10, 32'd5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL %s: got %h required %h", n, o, e); end
        end
    endtask

    task automatic test_step_zero;
        logic [31:0] e, o; string n;
        wr(8'h10, 32'd0);
        wr(8'h18, 32'd7);
        wr(8'h04, 32'h03);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (en !== 2'b00) begin failures++; $display("FAIL step0_no_tick: en=%b required 00", en); end
        end
        checks++;
        if (cycle !== 64'd16) begin failures++; $display("FAIL step0_cycle: got %0d required 16", cycle); end
        rd_exp("status_after_step0", 8'h00, 32'd2);
        rd_exp("irq_after_step0", 8'h18, 32'd3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL %s: got %h required %h", n, o, e); end
        end
    endtask

    task automatic test_irq_w1c;
        logic [31:0] e, o; string n;
        wr(8'h18, 32'd7);
        rd_exp("irq_w1c", 8'h18, 32'd0);
        rd_exp("irq_enable_readback", 8'h1C, 32'd2);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_w1c: got %b required 0", irq); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL %s: got %h required %h", n, o, e); end
        end
    endtask

    task automatic test_stall;
        logic [31:0] e, o; string n;
        wr(8'h04, 32'h01);
        repeat (2) @(negedge clk);
        stall = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (en !== 2'b00 || cycle !== 64'd17) begin
                failures++;
                $display("FAIL stall_cycle%0d: en=%b cycle=%0d required 00 and 17", i, en, cycle);
            end
            @(negedge clk);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (en[0] !== 1'b1 || cycle !== 64'd17) begin
            failures++; $display("FAIL stall_resume: en=%b cycle=%0d required en0=1 cycle=17", en, cycle);
        end
        @(negedge clk);
        checks++;
        if (cycle !== 64'd18) begin failures++; $display("FAIL stall_count_resume: got %0d required 18", cycle); end
        wr(8'h04, 32'h02);
        rd_exp("cycle_after_stall", 8'h08, 32'd21);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL %s: got %h required %h", n, o, e); end
        end
    endtask

    task automatic test_dut_reset;
        logic [31:0] e, o; string n;
        logic [3:0] vals [4];
        logic       req_lvl [4];
        vals = '{4'd2, 4'd3, 4'd2, 4'd0};
        req_lvl = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            wr(8'h14, 32'(vals[i]));
            checks++;
            if (dut_rst_n !== req_lvl[i]) begin
                failures++;
                $display("FAIL dut_reset_write%0d(%0d): got %b required %b", i, vals[i], dut_rst_n, req_lvl[i]);
            end
        end
        wr(8'h04, 32'h04);
        @(negedge clk);
        checks++;
        if (dut_rst_n !== 1'b1 || cycle !== 64'd0) begin
            failures++; $display("FAIL reset_cmd: rst_n=%b cycle=%0d required 1 and 0", dut_rst_n, cycle);
        end
        rd_exp("status_after_reset_cmd", 8'h00, 32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL %s: got %h required %h", n, o, e); end
        end
    endtask

`ifdef LOOM_EMU_BREAKPOINT_EN
    task automatic test_breakpoint;
        logic [31:0] e, o; string n;
        int ticks;
        wr(8'h20, 32'd100);
        wr(8'h24, 32'd0);
        wr(8'h04, 32'h01);
        ticks = 0;
        repeat (130) begin
            @(negedge clk);
            if (en[0] === 1'b1) ticks++;
        end
        checks++;
        if (ticks != 100) begin failures++; $display("FAIL bp_ticks: got %0d required 100", ticks); end
        rd_exp("bp_status", 8'h00, 32'd2);
        rd_exp("bp_cycle_lo", 8'h08, 32'd100);
        rd_exp("bp_irq", 8'h18, 32'd5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL %s: got %h required %h", n, o, e); end
        end
    endtask
`endif

    task automatic test_async_reset;
        logic [31:0] e, o; string n;
        wr(8'h04, 32'h01);
        repeat (2) @(negedge clk);
        checks++;
        if (en[0] !== 1'b1) begin failures++; $display("FAIL pre_async_running: en=%b required en0=1", en); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({en, dut_rst_n, cycle, irq, ack} !== '0) begin
            failures++;
            $display("FAIL async_reset: en=%b rst_n=%b cycle=%0d irq=%b ack=%b required all zero",
                     en, dut_rst_n, cycle, irq, ack);
        end
        @(negedge clk);
        rst = 1'b0;
        rd_exp("status_after_async", 8'h00, 32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n = name_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL %s: got %h required %h", n, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_div_run();
        test_step();
        test_step_zero();
        test_irq_w1c();
        test_stall();
        test_dut_reset();
`ifdef LOOM_EMU_BREAKPOINT_EN
        test_breakpoint();
`endif
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
